serial_frame_checker: RTL
=========================

# serial_frame_checker

Downstream checker for the serial stream leaving the self-test top level. It runs in the fast bit-clock domain and hunts for a 32-bit sync word. It then reassembles a fixed number of 32-bit payload words, MSB first, and compares each one against an incrementing reference sequence. The outcome is reported as an error count and a pass/fail flag for the board-level test harness.

## Interface

Clock is `clk`, reset is `rst`: one clock; reset is synchronous and active-high.

Parameters:
- SYNC_WORD, 32'hA5C3_F00F, frame delimiter; must be non-zero
- NUM_WORDS, 16, payload words per frame (1..65535)
- SEED, 32'h0000_0000, expected value of payload word 0
- ERR_W, 8, width of error counter
- TIMEOUT_BITS, 1024, enabled bits allowed in HUNT (used only with CHK_TIMEOUT_EN)

Ports:
- clk  in  1  bit clock
- rst  in  1  synchronous active-high reset
- restart  in  1  pulse: abort and re-hunt
- en  in  1  bit-valid qualifier; data_in sampled only when 1
- data_in  in  1  serial bit, MSB of each word first
- word_out  out  32  last assembled payload word
- word_valid  out  1  one-cycle strobe per payload word
- err_cnt  out  ERR_W  mismatching words, saturating
- locked  out  1  high while in PAYLOAD
- done  out  1  high in DONE
- pass  out  1  valid when done=1: err_cnt==0 and no timeout
- timeout  out  1  hunt timed out

## Operation

- Reset values: all outputs 0; state HUNT; shift register, bit, word and timeout counters 0.
- Priority: rst > restart > en. `restart`=1 behaves exactly like rst except that it is an ordinary input.
- With en=0, all state is frozen, except that word_valid returns to 0.
- HUNT:
  - On each enabled edge, shift data_in into the LSB of a 32-bit register.
  - If the new register value equals SYNC_WORD, go to PAYLOAD on that edge. Clear the bit and word counters, and set locked=1.
- PAYLOAD:
  - Shift data_in into the assembly register; the bit counter runs 0..31.
  - On the edge sampling bit 31, the following all happen:
    - word_out <= the assembled word; word_valid <= 1.
    - Compare the word against SEED + word_index, with modulo 2^32 wrap.
    - On mismatch, err_cnt increments, saturating at 2^ERR_W−1.
    - word_index increments.
  - When word_index reaches NUM_WORDS on that edge, go to DONE: locked <= 0, done <= 1.
  - pass <= 1 only if the final err_cnt (including the last word's comparison) is 0.
- DONE:
  - Hold all outputs.
  - Ignore data_in.
  - Leave only via rst or restart.
- In PAYLOAD, bit patterns equal to SYNC_WORD are ignored; there is no re-sync.

## Timing

- Lock latency: locked is high in the cycle after the edge that samples the last sync bit.
- Word latency: word_valid and word_out are visible in the cycle after the edge that samples bit 31. word_valid lasts one cycle.
- With en=1 continuously, strobes are spaced 32 cycles apart.
- done and pass rise in the same cycle as the final word_valid.
- restart in the same cycle as a word-complete edge: the restart wins. word_valid stays 0 and err_cnt is cleared.
- No combinational input-to-output paths; all outputs are registered.

## Configuration

- CHK_TIMEOUT_EN defined:
  - In HUNT, a counter increments on each enabled bit.
  - When it reaches TIMEOUT_BITS without a sync match, on that edge: timeout <= 1, done <= 1, pass <= 0, and the state goes to DONE.
  - A sync match on the same edge takes precedence: go to PAYLOAD, with no timeout.
- CHK_TIMEOUT_EN undefined: no counter is built, HUNT waits forever, and timeout is tied to 0.

## Test plan

- Reset: assert rst for 3 cycles with random data_in and en=1. All outputs are 0 during and after reset until the sync word is received.
- Clean frame: send 7 random bits, then SYNC_WORD, then words 0x0..0xF with en=1. Expected: locked one cycle after the sync word; 16 word_valid strobes 32 cycles apart with word_out=0..15; then done=1, pass=1, err_cnt=0.
- Single error: as the clean frame, but word 3 is sent as 0x7. Expected: err_cnt=1, done=1, pass=0, and word_out=0x7 on the 4th strobe.
- en gating with saturation:
  - Sending the clean frame with en toggling 1,0,1,0 gives the same results as the clean frame, with strobes 64 cycles apart.
  - With ERR_W=2 and all 16 words inverted, err_cnt=3 and pass=0.
- Restart mid-frame: pulse restart after the 5th strobe. Expected: the next cycle has locked=0 and err_cnt=0. A following clean frame then passes.
- Timeout (CHK_TIMEOUT_EN, TIMEOUT_BITS=1024): send 1024 zero bits with en=1. Expected: timeout=1, done=1, pass=0 after the 1024th edge. Sync ending on exactly the 1024th bit locks and does not time out.

Source files
------------

// File: rtl/serial_frame_checker_if.sv
// -----------------------------------------------------------------------------
// serial_frame_checker_if
// Bundles the serial input and the result outputs of serial_frame_checker.
//   master : drives restart / en / data_in, observes results (bench, harness)
//   slave  : the checker itself
// Signals:
//   restart    abort the current frame and go back to hunting for sync
//   en         bit-valid qualifier for data_in
//   data_in    serial bit, MSB of each word first
//   word_out   last assembled payload word
//   word_valid one-cycle strobe per payload word
//   err_cnt    saturating count of mismatching words (ERR_W bits)
//   locked     frame sync found, payload being received
//   done       frame finished (or hunt timed out)
//   pass       meaningful while done: no word errors and no timeout
//   timeout    hunt gave up before a sync word arrived
// -----------------------------------------------------------------------------
interface serial_frame_checker_if #(
  parameter int ERR_W = 8
);
  logic             restart;
  logic             en;
  logic             data_in;
  logic [31:0]      word_out;
  logic             word_valid;
  logic [ERR_W-1:0] err_cnt;
  logic             locked;
  logic             done;
  logic             pass;
  logic             timeout;

  modport master (
    output restart, en, data_in,
    input  word_out, word_valid, err_cnt, locked, done, pass, timeout
  );

  modport slave (
    input  restart, en, data_in,
    output word_out, word_valid, err_cnt, locked, done, pass, timeout
  );
endinterface

// File: rtl/serial_frame_checker.sv
// -----------------------------------------------------------------------------
// serial_frame_checker
// Hunts a serial bit stream for a 32-bit sync word, then reassembles NUM_WORDS
// payload words (MSB first) and compares each against SEED + word_index.
// Reports a saturating mismatch count and a pass flag when the frame is done.
//
// Ports:
//   clk  bit clock
//   rst  synchronous active-high reset
//   bus  serial_frame_checker_if.slave (restart/en/data_in in, results out)
//
// Optional feature (macro CHK_TIMEOUT_EN): give up hunting after TIMEOUT_BITS
// enabled bits without a sync match, reporting timeout/done with pass=0.
// Without the macro the hunt waits forever and timeout is tied low.
// -----------------------------------------------------------------------------
module serial_frame_checker #(
  parameter logic [31:0] SYNC_WORD    = 32'hA5C3_F00F,
  parameter int          NUM_WORDS    = 16,
  parameter logic [31:0] SEED         = 32'h0000_0000,
  parameter int          ERR_W        = 8,
  parameter int          TIMEOUT_BITS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_frame_checker_if.slave bus
);

  if (SYNC_WORD == 32'd0) begin : g_bad_sync
    $error("SYNC_WORD must be non-zero");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > 65535) begin : g_bad_words
    $error("NUM_WORDS out of range 1..65535");
  end
  if (TIMEOUT_BITS < 1) begin : g_bad_tmo
    $error("TIMEOUT_BITS must be at least 1");
  end

  typedef enum logic [1:0] {HUNT, PAYLOAD, DONE} state_t;

  state_t           state_q, state_d;
  logic [30:0]      sreg_q;     // only 31 bits kept; bit 32 is the incoming one
  logic [31:0]      sreg_nxt;
  logic [4:0]       bit_q;
  logic [15:0]      idx_q;
  logic [ERR_W-1:0] err_q, err_nxt;
  logic [31:0]      word_q;
  logic             wv_q, pass_q, tmo_q;
  logic             sync_hit, word_end, last_word, mismatch, tmo_hit, clr;

  assign clr      = rst || bus.restart;
  assign sreg_nxt = {sreg_q, bus.data_in};
  assign sync_hit = (state_q == HUNT) && bus.en && (sreg_nxt == SYNC_WORD);
  assign word_end = (state_q == PAYLOAD) && bus.en && (bit_q == 5'd31);
  assign mismatch = sreg_nxt != (SEED + {16'd0, idx_q});
  assign last_word = ({1'b0, idx_q} + 17'd1) == 17'(NUM_WORDS);
  assign err_nxt  = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;

`ifdef CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  logic [TW-1:0] tmo_cnt_q;

  // Sync match on the same edge wins over the timeout.
  assign tmo_hit = (state_q == HUNT) && bus.en && !sync_hit &&
                   (tmo_cnt_q == TW'(TIMEOUT_BITS - 1));

  always_ff @(posedge clk) begin
    if (clr)                         tmo_cnt_q <= '0;
    else if (state_q == HUNT && bus.en) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (sync_hit)               state_d = PAYLOAD;
               else if (tmo_hit)           state_d = DONE;
      PAYLOAD: if (word_end && last_word)  state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  // Outputs decoded from the state flop only, so still register-driven
  always_comb begin
    bus.locked = (state_q == PAYLOAD);
    bus.done   = (state_q == DONE);
  end

  // Datapath: shift/assemble, count, compare
  always_ff @(posedge clk) begin
    if (clr) begin
      sreg_q <= '0;
      bit_q  <= '0;
      idx_q  <= '0;
      err_q  <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
      pass_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      wv_q <= 1'b0;
      if (bus.en && state_q != DONE) begin
        sreg_q <= sreg_nxt[30:0];
        if (sync_hit) begin
          bit_q <= '0;
          idx_q <= '0;
        end
        if (tmo_hit) tmo_q <= 1'b1;
        if (state_q == PAYLOAD) begin
          bit_q <= bit_q + 1'b1;   // wraps 31 -> 0 at each word boundary
          if (word_end) begin
            word_q <= sreg_nxt;
            wv_q   <= 1'b1;
            err_q  <= err_nxt;
            idx_q  <= idx_q + 1'b1;
            if (last_word) pass_q <= (err_nxt == '0);
          end
        end
      end
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = wv_q;
  assign bus.err_cnt    = err_q;
  assign bus.pass       = pass_q;
  assign bus.timeout    = tmo_q;

endmodule
